// File: rtl/decode_pkg.sv
// Shared opcode constants, decoded-entry bundle and decode function.
// Used by decode_regfile_stage (optional forwarding: DEC_FWD_EN).
package decode_pkg;

    localparam logic [6:0] OP_R = 7'b0000001;
    localparam logic [6:0] OP_I = 7'b0000011;
    localparam logic [6:0] OP_U = 7'b0000111;
    localparam logic [6:0] OP_B = 7'b0001111;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [3:0]  aluop;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        hata;
    } dec_entry_t;

    // Field extraction only; register range checks need NREGS and live in the stage.
    function automatic dec_entry_t decode(input logic [31:0] k);
        dec_entry_t d;
        d        = '0;
        d.opcode = k[6:0];
        unique case (1'b1)
            (k[6:0] == OP_R): begin
                d.rs1   = k[19:15];
                d.rs2   = k[24:20];
                d.rd    = k[11:7];
                d.aluop = {k[30], k[14:12]};
            end
            (k[6:0] == OP_I): begin
                d.rs1   = k[19:15];
                d.rd    = k[11:7];
                d.aluop = {1'b0, k[14:12]};
                d.imm   = {20'b0, k[31:20]};
            end
            (k[6:0] == OP_U): begin
                d.rd  = k[11:7];
                d.imm = {12'b0, k[31:12]};
            end
            (k[6:0] == OP_B): begin
                d.rs1   = k[19:15];
                d.rs2   = k[24:20];
                d.aluop = {1'b0, k[14:12]};
                d.imm   = {19'b0, k[31:25], k[11:7], 1'b0};
            end
            default: d.hata = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_regfile_stage_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// Out-of-range indices read 0; register 0 is hardwired to 0 when ZERO_REG0.
module regfile_2r1w
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int ZERO_REG0 = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [$clog2(NREGS)-1:0] waddr_i,
    input  logic [XLEN-1:0]          wdata_i,
    input  logic [4:0]               raddr1_i,
    input  logic [4:0]               raddr2_i,
    output logic [XLEN-1:0]          rdata1_o,
    output logic [XLEN-1:0]          rdata2_o
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] mem_q [NREGS];
    logic            we_ok;
    logic            rd1_ok;
    logic            rd2_ok;

    assign we_ok = we_i && (32'(waddr_i) < NREGS)
                && !((ZERO_REG0 != 0) && (waddr_i == '0));

    assign rd1_ok = (32'(raddr1_i) < NREGS)
                 && !((ZERO_REG0 != 0) && (raddr1_i == 5'd0));
    assign rd2_ok = (32'(raddr2_i) < NREGS)
                 && !((ZERO_REG0 != 0) && (raddr2_i == 5'd0));

    assign rdata1_o = rd1_ok ? mem_q[raddr1_i[AW-1:0]] : '0;
    assign rdata2_o = rd2_ok ? mem_q[raddr2_i[AW-1:0]] : '0;

    // Storage: clear on reset, otherwise apply a qualified write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/decode_regfile_stage.sv
// Decode + operand-read stage with a one-entry output register.
// Define DEC_FWD_EN to bypass/refresh operands from the write port.
module decode_regfile_stage
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int ZERO_REG0 = 1,
    parameter int ERRCNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              komut,
    input  logic                     wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [XLEN-1:0]          wr_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [6:0]               opcode,
    output logic [3:0]               aluop,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [4:0]               rd,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    output logic [XLEN-1:0]          imm,
    output logic                     hata,
    output logic [ERRCNT_W-1:0]      err_count
);

    localparam logic [5:0] NR = 6'(NREGS);

    dec_entry_t          dec;
    dec_entry_t          ent_q, ent_d;
    logic                vld_q, vld_d;
    logic [XLEN-1:0]     d1_q, d1_d;
    logic [XLEN-1:0]     d2_q, d2_d;
    logic [ERRCNT_W-1:0] err_q, err_d;
    logic [XLEN-1:0]     rd1, rd2;
    logic                accept;
    logic                wr_ok;
    logic [4:0]          wa5;

    assign in_ready = !vld_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign wa5   = 5'(wr_addr);
    assign wr_ok = wr_en && (32'(wr_addr) < NREGS)
                && !((ZERO_REG0 != 0) && (wr_addr == '0));

    // Decode plus index range check against NREGS.
    always_comb begin
        dec = decode(komut);
        if (({1'b0, dec.rs1} >= NR) || ({1'b0, dec.rs2} >= NR)
            || ({1'b0, dec.rd} >= NR)) begin
            dec.hata = 1'b1;
        end
    end

    regfile_2r1w #(
        .XLEN      (XLEN),
        .NREGS     (NREGS),
        .ZERO_REG0 (ZERO_REG0)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wr_en),
        .waddr_i  (wr_addr),
        .wdata_i  (wr_data),
        .raddr1_i (dec.rs1),
        .raddr2_i (dec.rs2),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    // Next state: load on accept, drain on consume, count illegal entries.
    always_comb begin
        vld_d = vld_q;
        ent_d = ent_q;
        d1_d  = d1_q;
        d2_d  = d2_q;
        err_d = err_q;
        if (accept) begin
            vld_d = 1'b1;
            ent_d = dec;
            d1_d  = rd1;
            d2_d  = rd2;
`ifdef DEC_FWD_EN
            if (wr_ok && (wa5 == dec.rs1)) d1_d = wr_data;
            if (wr_ok && (wa5 == dec.rs2)) d2_d = wr_data;
`endif
            if (dec.hata && (err_q != '1)) begin
                err_d = err_q + ERRCNT_W'(1);
            end
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
`ifdef DEC_FWD_EN
        if (!accept && vld_q && !out_ready) begin
            if (wr_ok && (wa5 == ent_q.rs1)) d1_d = wr_data;
            if (wr_ok && (wa5 == ent_q.rs2)) d2_d = wr_data;
        end
`endif
    end

    // Output register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            ent_q <= '0;
            d1_q  <= '0;
            d2_q  <= '0;
            err_q <= '0;
        end else begin
            vld_q <= vld_d;
            ent_q <= ent_d;
            d1_q  <= d1_d;
            d2_q  <= d2_d;
            err_q <= err_d;
        end
    end

    assign out_valid = vld_q;
    assign opcode    = ent_q.opcode;
    assign aluop     = ent_q.aluop;
    assign rs1       = ent_q.rs1;
    assign rs2       = ent_q.rs2;
    assign rd        = ent_q.rd;
    assign imm       = XLEN'(ent_q.imm);
    assign hata      = ent_q.hata;
    assign rs1_data  = d1_q;
    assign rs2_data  = d2_q;
    assign err_count = err_q;

endmodule
